// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem read, single presented instruction,
// branch/sequential next-PC, and flush redirect with drain of an in-flight request.
module fetch_sequencer #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] PC,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] flush_pc
);

  // state   | meaning
  // S_FETCH | read outstanding at fetch_pc (or about to issue right after reset)
  // S_VALID | instr/PC presented to decode, waiting for instr_ready
  // S_DRAIN | flushed while a read was in flight; waiting for its ack to discard it
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [DATA_WIDTH-1:0] WORD_STEP  = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_req_addr;
  logic                  r_req;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;

  logic [DATA_WIDTH-1:0] w_flush_tgt;
  logic [DATA_WIDTH-1:0] w_next_pc;

  assign w_flush_tgt = flush_pc & ALIGN_MASK;
  assign w_next_pc   = (PCsrc ? (r_pc + ImmOp) : (r_pc + WORD_STEP)) & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC & ALIGN_MASK;
      r_req_addr <= RESET_PC & ALIGN_MASK;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            // First cycle out of reset: nothing is in flight, so any ack is stale.
            r_req <= 1'b1;
            if (flush) begin
              r_fetch_pc <= w_flush_tgt;
              r_req_addr <= w_flush_tgt;
            end else begin
              r_req_addr <= r_fetch_pc;
            end
          end else if (flush) begin
            r_fetch_pc <= w_flush_tgt;
            if (imem_ack) begin
              r_req_addr <= w_flush_tgt;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (imem_ack) begin
            r_instr <= imem_rdata;
            r_pc    <= r_fetch_pc;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_VALID;
          end
        end

        S_VALID: begin
          if (flush) begin
            r_valid    <= 1'b0;
            r_fetch_pc <= w_flush_tgt;
            r_req_addr <= w_flush_tgt;
            r_req      <= 1'b1;
            r_state    <= S_FETCH;
          end else if (instr_ready) begin
            r_valid    <= 1'b0;
            r_fetch_pc <= w_next_pc;
            r_req_addr <= w_next_pc;
            r_req      <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (flush) begin
            r_fetch_pc <= w_flush_tgt;
          end
          if (imem_ack) begin
            r_req_addr <= flush ? w_flush_tgt : r_fetch_pc;
            r_state    <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_req_addr;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign PC          = r_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, branch, wrap, flush in each state, reset in drain.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] PC;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks;
  int n_errors;

  fetch_sequencer #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .PC         (PC),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .flush      (flush),
    .flush_pc   (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    PCsrc       = 1'b0;
    ImmOp       = '0;
    flush       = 1'b0;
    flush_pc    = '0;

    step();
    step();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'd0);
    chk("rst_pc",    PC,                   32'd0);

    rst_n = 1'b1;
    step();
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         32'h0);

    // zero-wait ack, ready held high, sequential
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("seq_req",   {31'd0, imem_req},    32'd1);
      chk("seq_addr",  imem_addr,            32'(4 * k));
      chk("seq_novld", {31'd0, instr_valid}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1000_0000 + 32'(k);
      step();
      imem_ack = 1'b0;
      chk("seq_valid", {31'd0, instr_valid}, 32'd1);
      chk("seq_noreq", {31'd0, imem_req},    32'd0);
      chk("seq_instr", instr,                32'h1000_0000 + 32'(k));
      chk("seq_pc",    PC,                   32'(4 * k));
      step();
    end
    instr_ready = 1'b0;
    chk("seq_end_addr", imem_addr, 32'h10);

    // backward branch from 0x10 by -8
    imem_ack = 1'b1; imem_rdata = 32'hB000_0010;
    step();
    imem_ack = 1'b0;
    chk("br_pc", PC, 32'h10);
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    step();
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    chk("br_addr",  imem_addr,            32'h08);
    chk("br_novld", {31'd0, instr_valid}, 32'd0);

    // decode stall holds instr and PC
    imem_ack = 1'b1; imem_rdata = 32'hC0DE_0008;
    step();
    imem_ack = 1'b0;
    step();
    step();
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_instr", instr,                32'hC0DE_0008);
    chk("stall_pc",    PC,                   32'h08);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("stall_next", imem_addr, 32'h0C);

    // flush with same-cycle ack: data dropped, redirect to aligned 0x22 -> 0x20
    flush = 1'b1; flush_pc = 32'h22; imem_ack = 1'b1; imem_rdata = 32'hBAD0_000C;
    step();
    flush = 1'b0; imem_ack = 1'b0;
    chk("fack_req",   {31'd0, imem_req},    32'd1);
    chk("fack_addr",  imem_addr,            32'h20);
    chk("fack_novld", {31'd0, instr_valid}, 32'd0);

    // flush without ack: drain 0x20 (ack on third cycle), then fetch 0x100
    flush = 1'b1; flush_pc = 32'h100;
    step();
    flush = 1'b0;
    chk("drn_addr1",  imem_addr,            32'h20);
    chk("drn_req1",   {31'd0, imem_req},    32'd1);
    step();
    chk("drn_addr2",  imem_addr,            32'h20);
    chk("drn_novld",  {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0020;
    step();
    imem_ack = 1'b0;
    chk("drn_after_addr",  imem_addr,            32'h100);
    chk("drn_after_req",   {31'd0, imem_req},    32'd1);
    chk("drn_after_novld", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0100;
    step();
    imem_ack = 1'b0;
    chk("post_drn_instr", instr, 32'hAAAA_0100);
    chk("post_drn_pc",    PC,    32'h100);

    // flush wins over ready/PCsrc in VALID
    flush = 1'b1; flush_pc = 32'h43; instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'h40;
    step();
    flush = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    chk("vflush_addr",  imem_addr,            32'h40);
    chk("vflush_novld", {31'd0, instr_valid}, 32'd0);
    chk("vflush_req",   {31'd0, imem_req},    32'd1);

    // second flush while draining replaces the target
    flush = 1'b1; flush_pc = 32'h300;
    step();
    flush_pc = 32'h404;
    step();
    flush = 1'b0;
    chk("dd_hold", imem_addr, 32'h40);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("dd_addr",  imem_addr,            32'h404);
    chk("dd_novld", {31'd0, instr_valid}, 32'd0);

    // address wrap from 0xFFFF_FFFC
    flush = 1'b1; flush_pc = 32'hFFFF_FFFF; imem_ack = 1'b1;
    step();
    flush = 1'b0;
    chk("wrap_fetch", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = 32'h7777_FFFC;
    step();
    imem_ack = 1'b0;
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);

    // reset during drain, stray ack at release
    flush = 1'b1; flush_pc = 32'h50;
    step();
    flush = 1'b0;
    chk("pre_rst_addr", imem_addr, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rstd_req",   {31'd0, imem_req},    32'd0);
    chk("rstd_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("rstd_req2",  {31'd0, imem_req},    32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h5757_5757;
    rst_n = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("rel_req",   {31'd0, imem_req},    32'd1);
    chk("rel_addr",  imem_addr,            32'h0);
    chk("rel_novld", {31'd0, instr_valid}, 32'd0);
    step();
    chk("rel_novld2", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk("rel_valid", {31'd0, instr_valid}, 32'd1);
    chk("rel_instr", instr,                32'h1234_5678);
    chk("rel_pc",    PC,                   32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
